// File: rtl/hpc2_share_feeder_pkg.sv
// Shared definitions for the HPC2 share feeder: FSM states, PRNG constants
// and the xorshift64 step function.
package hpc2_share_feeder_pkg;

   typedef enum logic [1:0] {
      ST_UNSEEDED = 2'd0,
      ST_WARM     = 2'd1,
      ST_RUN      = 2'd2
   } feeder_state_e;

   // An all-zero xorshift state is a fixed point, so a zero seed is replaced.
   localparam logic [63:0] ZERO_SEED_SUB = 64'h9E37_79B9_7F4A_7C15;

   localparam int XS_SHL_A = 13;
   localparam int XS_SHR_B = 7;
   localparam int XS_SHL_C = 17;

   localparam int DEFAULT_HPC2_LATENCY = 3;

   function automatic logic [63:0] xs64_next(input logic [63:0] x);
      logic [63:0] t;
      t = x ^ (x << XS_SHL_A);
      t = t ^ (t >> XS_SHR_B);
      t = t ^ (t << XS_SHL_C);
      return t;
   endfunction

endpackage

// File: rtl/hpc2_share_feeder_prng.sv
// xorshift64 PRNG: state register with seed load (zero seed substituted)
// and per-cycle step. Exposes the low OUT_W state bits as the random bus.
module hpc2_prng_xs64
   import hpc2_share_feeder_pkg::*;
#(
   parameter logic [63:0] SEED  = 64'h0000_0000_0000_0001,
   parameter int          OUT_W = 56
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [63:0]      seed,
   input  logic             step,
   output logic [OUT_W-1:0] bus
);

   logic [63:0] state_q;
   logic [63:0] state_d;

   // Load wins over step; the state holds when neither is requested.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (seed == 64'd0) ? ZERO_SEED_SUB : seed;
      end else if (step) begin
         state_d = xs64_next(state_q);
      end
   end

   // State register, reset to the build-time seed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign bus = state_q[OUT_W-1:0];

endmodule

// File: rtl/hpc2_share_feeder.sv
// Masking front-end for a 3-share HPC2 AND gadget: splits operands into
// Boolean shares, supplies fresh gadget randomness every RUN cycle, tracks
// issued operations through the gadget latency and recombines the result.
// Optional build macro HPC2_FEEDER_CHECK_EN adds a sticky result checker
// (err); without it err is tied low.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_UNSEEDED | after reset, PRNG held, no operands accepted
// ST_WARM     | PRNG stepping WARMUP times to discard post-seed outputs
// ST_RUN      | operands accepted, shares/randomness refreshed each cycle
module hpc2_share_feeder
   import hpc2_share_feeder_pkg::*;
#(
   parameter int          WIDTH        = 8,
   parameter logic [63:0] SEED         = 64'h0000_0000_0000_0001,
   parameter int          WARMUP       = 4,
   parameter int          HPC2_LATENCY = DEFAULT_HPC2_LATENCY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed_load,
   input  logic [63:0]      seed,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] a0,
   output logic [WIDTH-1:0] a1,
   output logic [WIDTH-1:0] a2,
   output logic [WIDTH-1:0] b0,
   output logic [WIDTH-1:0] b1,
   output logic [WIDTH-1:0] b2,
   output logic [WIDTH-1:0] r01,
   output logic [WIDTH-1:0] r02,
   output logic [WIDTH-1:0] r12,
   output logic             share_valid,
   input  logic [WIDTH-1:0] c0,
   input  logic [WIDTH-1:0] c1,
   input  logic [WIDTH-1:0] c2,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             err
);

   // Seven WIDTH-wide slices are taken from the 64-bit PRNG state.
   localparam int          BUS_W     = 7 * WIDTH;
   localparam logic [3:0]  WARM_LAST = (WARMUP == 0) ? 4'd0 : 4'(WARMUP - 1);

   feeder_state_e    state_q, state_d;
   logic [3:0]       warm_cnt_q, warm_cnt_d;
   logic             prng_load;
   logic             prng_step;
   logic [BUS_W-1:0] prng_bus;
   logic             fire;

   logic [WIDTH-1:0] a0_q, a1_q, a2_q, b0_q, b1_q, b2_q;
   logic [WIDTH-1:0] a0_d, a1_d, a2_d, b0_d, b1_d, b2_d;
   logic [WIDTH-1:0] r01_q, r02_q, r12_q;
   logic [WIDTH-1:0] r01_d, r02_d, r12_d;
   logic             share_valid_q, share_valid_d;
   logic [HPC2_LATENCY-1:0] dly_q, dly_d;

   logic [WIDTH-1:0] sl_a1, sl_a2, sl_b1, sl_b2, sl_r01, sl_r02, sl_r12;

   hpc2_prng_xs64 #(
      .SEED  (SEED),
      .OUT_W (BUS_W)
   ) u_prng (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (prng_load),
      .seed  (seed),
      .step  (prng_step),
      .bus   (prng_bus)
   );

   assign sl_a1  = prng_bus[0*WIDTH +: WIDTH];
   assign sl_a2  = prng_bus[1*WIDTH +: WIDTH];
   assign sl_b1  = prng_bus[2*WIDTH +: WIDTH];
   assign sl_b2  = prng_bus[3*WIDTH +: WIDTH];
   assign sl_r01 = prng_bus[4*WIDTH +: WIDTH];
   assign sl_r02 = prng_bus[5*WIDTH +: WIDTH];
   assign sl_r12 = prng_bus[6*WIDTH +: WIDTH];

   // A reseed cycle never accepts an operand, so seed_load beats fire.
   assign in_ready = (state_q == ST_RUN) && !seed_load;
   assign fire     = in_valid && in_ready;

   // FSM next state, warm-up counting and PRNG load/step control.
   always_comb begin
      state_d    = state_q;
      warm_cnt_d = warm_cnt_q;
      prng_load  = 1'b0;
      prng_step  = 1'b0;
      case (state_q)
         ST_UNSEEDED: begin
         end
         ST_WARM: begin
            prng_step = 1'b1;
            if (warm_cnt_q == WARM_LAST) begin
               state_d = ST_RUN;
            end else begin
               warm_cnt_d = warm_cnt_q + 4'd1;
            end
         end
         ST_RUN: begin
            prng_step = 1'b1;
         end
         default: begin
            state_d = ST_UNSEEDED;
         end
      endcase
      if (seed_load) begin
         prng_load  = 1'b1;
         warm_cnt_d = 4'd0;
         state_d    = (WARMUP == 0) ? ST_RUN : ST_WARM;
      end
   end

   // Share and randomness refresh: every RUN cycle draws new PRNG slices;
   // an idle cycle puts a masked zero on the bus instead of a stale operand.
   always_comb begin
      a0_d  = a0_q;
      a1_d  = a1_q;
      a2_d  = a2_q;
      b0_d  = b0_q;
      b1_d  = b1_q;
      b2_d  = b2_q;
      r01_d = r01_q;
      r02_d = r02_q;
      r12_d = r12_q;
      if (state_q == ST_RUN) begin
         a1_d  = sl_a1;
         a2_d  = sl_a2;
         b1_d  = sl_b1;
         b2_d  = sl_b2;
         r01_d = sl_r01;
         r02_d = sl_r02;
         r12_d = sl_r12;
         a0_d  = (fire ? a : '0) ^ sl_a1 ^ sl_a2;
         b0_d  = (fire ? b : '0) ^ sl_b1 ^ sl_b2;
      end
   end

   // Issue strobe and its delay line matching the gadget latency.
   always_comb begin
      share_valid_d = fire;
      dly_d         = dly_q << 1;
      dly_d[0]      = share_valid_q;
   end

   // Control and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_UNSEEDED;
         warm_cnt_q    <= 4'd0;
         a0_q          <= '0;
         a1_q          <= '0;
         a2_q          <= '0;
         b0_q          <= '0;
         b1_q          <= '0;
         b2_q          <= '0;
         r01_q         <= '0;
         r02_q         <= '0;
         r12_q         <= '0;
         share_valid_q <= 1'b0;
         dly_q         <= '0;
      end else begin
         state_q       <= state_d;
         warm_cnt_q    <= warm_cnt_d;
         a0_q          <= a0_d;
         a1_q          <= a1_d;
         a2_q          <= a2_d;
         b0_q          <= b0_d;
         b1_q          <= b1_d;
         b2_q          <= b2_d;
         r01_q         <= r01_d;
         r02_q         <= r02_d;
         r12_q         <= r12_d;
         share_valid_q <= share_valid_d;
         dly_q         <= dly_d;
      end
   end

   assign a0          = a0_q;
   assign a1          = a1_q;
   assign a2          = a2_q;
   assign b0          = b0_q;
   assign b1          = b1_q;
   assign b2          = b2_q;
   assign r01         = r01_q;
   assign r02         = r02_q;
   assign r12         = r12_q;
   assign share_valid = share_valid_q;
   assign res_valid   = dly_q[HPC2_LATENCY-1];
   assign res_data    = c0 ^ c1 ^ c2;

`ifdef HPC2_FEEDER_CHECK_EN
   // Stage 0 captures a&b at the fire edge, so stage HPC2_LATENCY lines up
   // with res_valid for the same operation.
   logic [WIDTH-1:0] exp_q [HPC2_LATENCY+1];
   logic [WIDTH-1:0] exp_d [HPC2_LATENCY+1];
   logic             err_q, err_d;

   // Expected-result pipeline and sticky mismatch flag.
   always_comb begin
      exp_d[0] = fire ? (a & b) : '0;
      for (int i = 1; i <= HPC2_LATENCY; i++) begin
         exp_d[i] = exp_q[i-1];
      end
      err_d = err_q | (res_valid && (res_data != exp_q[HPC2_LATENCY]));
   end

   // Checker registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= HPC2_LATENCY; i++) begin
            exp_q[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i <= HPC2_LATENCY; i++) begin
            exp_q[i] <= exp_d[i];
         end
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hpc2_share_feeder.sv
// Bench for hpc2_share_feeder: table of first-fire vectors after a reseed,
// a model HPC2 gadget feeding c0..c2, and a scoreboard of expected results.
module tb_hpc2_share_feeder;

   localparam int LAT = 3;

`ifdef HPC2_FEEDER_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic        clk, rst_n, seed_load, in_valid;
   logic [63:0] seed;
   logic [7:0]  a, b, c0, c1, c2;
   logic        in_ready, share_valid, res_valid, err;
   logic [7:0]  a0, a1, a2, b0, b1, b2, r01, r02, r12, res_data;

   logic        w_in_ready, w_share_valid, w_res_valid, w_err;
   logic [7:0]  w_a0, w_a1, w_a2, w_b0, w_b1, w_b2, w_r01, w_r02, w_r12, w_res_data;

   hpc2_share_feeder #(.WIDTH(8), .SEED(64'h1), .WARMUP(0), .HPC2_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
      .r01(r01), .r02(r02), .r12(r12), .share_valid(share_valid),
      .c0(c0), .c1(c1), .c2(c2), .res_valid(res_valid), .res_data(res_data), .err(err));

   hpc2_share_feeder #(.WIDTH(8), .SEED(64'h1), .WARMUP(2), .HPC2_LATENCY(LAT)) dut_w (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
      .in_valid(in_valid), .in_ready(w_in_ready), .a(a), .b(b),
      .a0(w_a0), .a1(w_a1), .a2(w_a2), .b0(w_b0), .b1(w_b1), .b2(w_b2),
      .r01(w_r01), .r02(w_r02), .r12(w_r12), .share_valid(w_share_valid),
      .c0(c0), .c1(c1), .c2(c2), .res_valid(w_res_valid), .res_data(w_res_data), .err(w_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int res_cnt = 0;
   int edge_cnt = 0;

   typedef struct {
      logic [7:0] data;
      int         idx;
   } sb_t;
   sb_t sb[$];

   logic [7:0] exp_xor = 8'h00;
   logic [7:0] flip = 8'h00;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] xs_model(input logic [63:0] x);
      logic [63:0] t;
      t = x ^ (x << 13);
      t = t ^ (t >> 7);
      t = t ^ (t << 17);
      return t;
   endfunction

   // Model HPC2 gadget: recombine the bus shares, AND, remask, 3-cycle pipe.
   logic [7:0] gp [3];
   logic [7:0] m1, m2;
   always @(posedge clk) begin
      gp[0] <= (a0 ^ a1 ^ a2) & (b0 ^ b1 ^ b2);
      gp[1] <= gp[0];
      gp[2] <= gp[1];
      m1    <= 8'($urandom);
      m2    <= 8'($urandom);
   end
   assign c0 = gp[2] ^ m1 ^ m2;
   assign c1 = m1 ^ flip;
   assign c2 = m2;

   // Scoreboard push at each accepted operation.
   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         sb.push_back('{data: (a & b) ^ exp_xor, idx: edge_cnt});
      end
      edge_cnt <= edge_cnt + 1;
   end

   // Result monitor: data and latency against the scoreboard.
   always @(negedge clk) begin
      sb_t e;
      if (rst_n && res_valid) begin
         res_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res_unexpected: got res_valid=1 expected no result (edge %0d)", edge_cnt);
         end else begin
            e = sb.pop_front();
            chk("res_data", 64'(res_data), 64'(e.data));
            chk("res_latency", 64'(edge_cnt), 64'(e.idx + LAT + 1));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [63:0] seed;
      logic [7:0]  a, b;
      logic [7:0]  a0, a1, a2, b0, b1, b2, r01, r02, r12;
      logic [63:0] nxt;
   } vec_t;
   vec_t vecs[3];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int saved;
      logic [63:0] wx;

      vecs[0] = '{64'h1, 8'hFF, 8'h0F, 8'hFE, 8'h01, 8'h00, 8'h0F, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 64'h0000_0000_4082_2041};
      vecs[1] = '{64'h0, 8'h5A, 8'hC3, 8'h33, 8'h15, 8'h7C, 8'hF6, 8'h4A, 8'h7F,
                  8'hB9, 8'h79, 8'h37, xs_model(64'h9E37_79B9_7F4A_7C15)};
      vecs[2] = '{64'h0123_4567_89AB_CDEF, 8'h3C, 8'hA5, 8'h1E, 8'hEF, 8'hCD, 8'h87, 8'hAB, 8'h89,
                  8'h67, 8'h45, 8'h23, xs_model(64'h0123_4567_89AB_CDEF)};

      rst_n = 1'b0; seed_load = 1'b0; seed = 64'h0; in_valid = 1'b0; a = 8'h0; b = 8'h0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Unseeded: offered operands are never accepted.
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         tick();
         chk("unseeded_in_ready", 64'(in_ready), 64'(0));
         chk("unseeded_share_valid", 64'(share_valid), 64'(0));
      end
      chk("unseeded_bus", {a0, a1, a2, b0, b1, b2, r01, r02}, 64'h0);
      chk("unseeded_r12_res", {r12, res_valid, err}, 64'h0);
      in_valid = 1'b0;

      // Reseed then fire once per table row.
      for (int i = 0; i < 3; i++) begin
         seed_load = 1'b1; seed = vecs[i].seed; in_valid = 1'b1;
         #1 chk("reseed_in_ready", 64'(in_ready), 64'(0));
         tick();
         seed_load = 1'b0; a = vecs[i].a; b = vecs[i].b;
         #1 chk("run_in_ready", 64'(in_ready), 64'(1));
         tick();
         in_valid = 1'b0;
         chk("vec_share_valid", 64'(share_valid), 64'(1));
         chk("vec_a", {a0, a1, a2}, {vecs[i].a0, vecs[i].a1, vecs[i].a2});
         chk("vec_b", {b0, b1, b2}, {vecs[i].b0, vecs[i].b1, vecs[i].b2});
         chk("vec_r", {r01, r02, r12}, {vecs[i].r01, vecs[i].r02, vecs[i].r12});
         tick();
         chk("next_share_valid", 64'(share_valid), 64'(0));
         chk("next_state_slices", {r12, r02, r01, b2, b1, a2, a1}, vecs[i].nxt[55:0]);
         chk("next_masked_zero", {a0, b0}, {a1 ^ a2, b1 ^ b2});
      end
      repeat (6) tick();
      chk("table_drained", 64'(sb.size()), 64'(0));

      // Ten back-to-back fires through the model gadget.
      saved = res_cnt;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         tick();
         chk("b2b_share_valid", 64'(share_valid), 64'(1));
      end
      in_valid = 1'b0;
      repeat (6) tick();
      chk("b2b_res_count", 64'(res_cnt - saved), 64'(10));
      chk("b2b_drained", 64'(sb.size()), 64'(0));
      chk("b2b_err", 64'(err), 64'(0));

      // Single-bit corruption of c1 for one operation.
      exp_xor = 8'h02; a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; exp_xor = 8'h00; flip = 8'h02;
      repeat (3) tick();
      chk("err_before_res", 64'(err), 64'(0));
      tick();
      chk("err_after_res", 64'(err), 64'(EXP_ERR));
      flip = 8'h00;
      repeat (5) tick();
      chk("err_sticky", 64'(err), 64'(EXP_ERR));

      // Reseed mid-RUN with two operations in flight; WARMUP=2 instance
      // must hold off fires for two cycles.
      in_valid = 1'b1;
      repeat (2) begin
         a = 8'($urandom); b = 8'($urandom);
         tick();
      end
      seed_load = 1'b1; seed = 64'h1;
      #1 chk("midrun_reseed_ready", 64'(in_ready), 64'(0));
      tick();
      seed_load = 1'b0;
      chk("midrun_reseed_no_fire", 64'(share_valid), 64'(0));
      chk("warm_ready_0", 64'(w_in_ready), 64'(0));
      a = 8'h96; b = 8'h5A;
      tick();
      chk("warm_ready_1", 64'(w_in_ready), 64'(0));
      chk("warm_sv_1", 64'(w_share_valid), 64'(0));
      tick();
      chk("warm_ready_2", 64'(w_in_ready), 64'(1));
      chk("warm_sv_2", 64'(w_share_valid), 64'(0));
      tick();
      in_valid = 1'b0;
      wx = xs_model(xs_model(64'h1));
      chk("warm_sv_3", 64'(w_share_valid), 64'(1));
      chk("warm_slices", {w_r12, w_r02, w_r01, w_b2, w_b1, w_a2, w_a1}, wx[55:0]);
      chk("warm_a0", 64'(w_a0), 64'(8'h96 ^ wx[7:0] ^ wx[15:8]));
      repeat (6) tick();
      chk("midrun_drained", 64'(sb.size()), 64'(0));

      // Reset with two operations in flight: no results may follow.
      in_valid = 1'b1;
      repeat (2) begin
         a = 8'($urandom); b = 8'($urandom);
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      sb.delete();
      saved = res_cnt;
      tick();
      rst_n = 1'b1;
      repeat (8) tick();
      chk("rst_no_res", 64'(res_cnt - saved), 64'(0));
      chk("rst_unseeded", 64'(in_ready), 64'(0));
      chk("rst_outputs", {share_valid, res_valid, err, a0, b0, r01}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
